// File: rtl/weight_mem_pkg.sv
// Shared types and constants for the weight memory arbiter.
package weight_mem_pkg;

  // Sequencer states: zero-fill clear, idle/arbitrate, read, write.
  typedef enum logic [3:0] {
    ST_CLEAR_SETUP,
    ST_CLEAR_PULSE,
    ST_CLEAR_HOLD,
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  // Port select encoding used by the arbiter and the sequencer.
  localparam logic P_SEL = 1'b0;
  localparam logic D_SEL = 1'b1;

  // Memory-side cycles per access (the ack edge returns to IDLE).
  localparam int WRITE_CYCLES = 3;
  localparam int READ_CYCLES  = 2;

endpackage

// File: rtl/mem_rr_starve_arb.sv
// Grant decision between soft clear, predictor port P and debug port D.
// P normally wins; D is forced once P has been granted STARVE_LIMIT
// times in a row while D was waiting.
module mem_rr_starve_arb
  import weight_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_arb_en,
  input  logic i_clear_req,
  input  logic i_p_req,
  input  logic i_d_req,
  output logic o_clear_grant,
  output logic o_port_grant,
  output logic o_port_sel
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;

  // Priority: clear, starved D, P, D.
  always_comb begin
    o_clear_grant = i_arb_en & i_clear_req;
    o_port_grant  = i_arb_en & ~i_clear_req & (i_p_req | i_d_req);
    o_port_sel    = P_SEL;
    if (i_d_req && ((r_starve_cnt == LIMIT) || !i_p_req)) begin
      o_port_sel = D_SEL;
    end
  end

  // Count P grants taken while D waits; cleared by a D grant or idle D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_d_req) begin
      r_starve_cnt <= '0;
    end else if (o_port_grant) begin
      if (o_port_sel == D_SEL) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_mem_arbiter.sv
// Owner of the single-port latch weight memory. Shares it between the
// perceptron port P and the debug port D, sequences latch write timing
// (setup / pulse / hold) and zero-fills the memory after reset or on
// request.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata stable and
// keeps them until x_ack pulses for one cycle (with x_rdata for reads).
// If x_req is still high at the edge ending the ack cycle, that is a new
// request.
module weight_mem_arbiter
  import weight_mem_pkg::*;
#(
  parameter int STORAGE_B      = 96,
  parameter int MEM_ADDR_WIDTH = $clog2(STORAGE_B),
  parameter int DATA_WIDTH     = 8,
  parameter int STARVE_LIMIT   = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_p_req,
  input  logic                      i_p_we,
  input  logic [MEM_ADDR_WIDTH-1:0] i_p_addr,
  input  logic [DATA_WIDTH-1:0]     i_p_wdata,
  output logic                      o_p_ack,
  output logic [DATA_WIDTH-1:0]     o_p_rdata,
  input  logic                      i_d_req,
  input  logic                      i_d_we,
  input  logic [MEM_ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0]     i_d_wdata,
  output logic                      o_d_ack,
  output logic [DATA_WIDTH-1:0]     o_d_rdata,
  output logic                      o_addr_err,
  input  logic                      i_clear_req,
  output logic                      o_clear_done,
  output logic                      o_busy,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                      o_mem_wr_en,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output state_t                    o_state
);

  localparam int AW1 = MEM_ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] ADDR_END = AW1'(STORAGE_B);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(STORAGE_B - 1);

  state_t                    r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_clr_addr;
  logic                      r_sel;
  logic                      r_err;
  logic                      r_p_ack;
  logic                      r_d_ack;
  logic [DATA_WIDTH-1:0]     r_p_rdata;
  logic [DATA_WIDTH-1:0]     r_d_rdata;
  logic                      r_addr_err;
  logic                      r_clear_done;
  logic                      r_busy;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic                      r_mem_wr_en;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;

  logic                      w_clear_grant;
  logic                      w_port_grant;
  logic                      w_port_sel;
  logic                      w_req_we;
  logic [MEM_ADDR_WIDTH-1:0] w_req_addr;
  logic [DATA_WIDTH-1:0]     w_req_wdata;
  logic                      w_in_range;

  mem_rr_starve_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_arb_en      (r_state == ST_IDLE),
    .i_clear_req   (i_clear_req),
    .i_p_req       (i_p_req),
    .i_d_req       (i_d_req),
    .o_clear_grant (w_clear_grant),
    .o_port_grant  (w_port_grant),
    .o_port_sel    (w_port_sel)
  );

  // Fields of the port the arbiter picked this cycle.
  always_comb begin
    w_req_we    = (w_port_sel == D_SEL) ? i_d_we    : i_p_we;
    w_req_addr  = (w_port_sel == D_SEL) ? i_d_addr  : i_p_addr;
    w_req_wdata = (w_port_sel == D_SEL) ? i_d_wdata : i_p_wdata;
    w_in_range  = ({1'b0, w_req_addr} < ADDR_END);
  end

  // Sequencer: clear sweep, arbitration, read and write timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR_SETUP : ST_IDLE;
      r_busy       <= (CLEAR_ON_RESET != 0);
      r_clr_addr   <= '0;
      r_sel        <= P_SEL;
      r_err        <= 1'b0;
      r_p_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_p_rdata    <= '0;
      r_d_rdata    <= '0;
      r_addr_err   <= 1'b0;
      r_clear_done <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wr_en  <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      r_p_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_addr_err   <= 1'b0;
      r_clear_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_clear_grant) begin
            r_state     <= ST_CLEAR_SETUP;
            r_busy      <= 1'b1;
            r_clr_addr  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end else if (w_port_grant) begin
            r_busy <= 1'b1;
            r_sel  <= w_port_sel;
            r_err  <= ~w_in_range;
            // Out-of-range requests leave the memory bus untouched.
            if (w_in_range) begin
              r_mem_addr <= w_req_addr;
            end
            if (w_req_we) begin
              r_state <= ST_WR_SETUP;
              if (w_in_range) begin
                r_mem_wdata <= w_req_wdata;
              end
            end else begin
              r_state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: r_state <= ST_RD_CAP;
        ST_RD_CAP: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_addr_err <= r_err;
          if (r_sel == D_SEL) begin
            r_d_ack   <= 1'b1;
            r_d_rdata <= r_err ? '0 : i_mem_rdata;
          end else begin
            r_p_ack   <= 1'b1;
            r_p_rdata <= r_err ? '0 : i_mem_rdata;
          end
        end
        ST_WR_SETUP: begin
          r_state     <= ST_WR_PULSE;
          r_mem_wr_en <= ~r_err;
        end
        ST_WR_PULSE: begin
          r_state     <= ST_WR_HOLD;
          r_mem_wr_en <= 1'b0;
        end
        ST_WR_HOLD: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_addr_err <= r_err;
          if (r_sel == D_SEL) begin
            r_d_ack <= 1'b1;
          end else begin
            r_p_ack <= 1'b1;
          end
        end
        ST_CLEAR_SETUP: begin
          r_state     <= ST_CLEAR_PULSE;
          r_mem_wr_en <= 1'b1;
        end
        ST_CLEAR_PULSE: begin
          r_state     <= ST_CLEAR_HOLD;
          r_mem_wr_en <= 1'b0;
        end
        ST_CLEAR_HOLD: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b1;
          end else begin
            r_state    <= ST_CLEAR_SETUP;
            r_clr_addr <= r_clr_addr + 1'b1;
            r_mem_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_p_ack      = r_p_ack;
  assign o_p_rdata    = r_p_rdata;
  assign o_d_ack      = r_d_ack;
  assign o_d_rdata    = r_d_rdata;
  assign o_addr_err   = r_addr_err;
  assign o_clear_done = r_clear_done;
  assign o_busy       = r_busy;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wr_en  = r_mem_wr_en;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_state      = r_state;

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Bench for weight_mem_arbiter: behavioural latch memory, reference
// byte array, randomized accesses from both ports.
`timescale 1ns/1ps
module tb_weight_mem_arbiter;
  import weight_mem_pkg::*;

  localparam int STORAGE_B    = 96;
  localparam int AW           = 7;
  localparam int DW           = 8;
  localparam int STARVE_LIMIT = 4;
  localparam int CLEAR_CYC    = 3 * STORAGE_B;
  localparam int RD_LAT       = 3;
  localparam int WR_LAT       = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          p_req = 0, p_we = 0, d_req = 0, d_we = 0, clear_req = 0;
  logic [AW-1:0] p_addr = '0, d_addr = '0;
  logic [DW-1:0] p_wdata = '0, d_wdata = '0;
  logic          p_ack, d_ack, addr_err, clear_done, busy, mem_wr_en;
  logic [DW-1:0] p_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  state_t        state;

  weight_mem_arbiter #(
    .STORAGE_B(STORAGE_B), .MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .STARVE_LIMIT(STARVE_LIMIT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_p_req(p_req), .i_p_we(p_we), .i_p_addr(p_addr), .i_p_wdata(p_wdata),
    .o_p_ack(p_ack), .o_p_rdata(p_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata),
    .o_addr_err(addr_err), .i_clear_req(clear_req), .o_clear_done(clear_done),
    .o_busy(busy), .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_state(state)
  );

  // behavioural latch memory, preloaded with nonzero garbage
  logic [DW-1:0] bmem [0:127];
  logic mem_filled = 1'b0;
  int   wr_pulses = 0;
  int   bad_wr = 0;
  assign mem_rdata = bmem[mem_addr];
  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < 128; i++) bmem[i] <= DW'($urandom_range(1, 255));
      mem_filled <= 1'b1;
    end else if (mem_wr_en) begin
      bmem[mem_addr] <= mem_wdata;
      wr_pulses++;
      if (int'(mem_addr) >= STORAGE_B) bad_wr++;
    end
  end

  // reference model
  logic [DW-1:0] ref_mem [0:STORAGE_B-1];
  logic [DW-1:0] last_p_rd = '0, last_d_rd = '0;
  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int i = 0; i < STORAGE_B; i++) ref_mem[i] = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, STORAGE_B - 1));
  endfunction

  // driver: call at a negedge; returns at the negedge where ack is seen
  task automatic do_access(input logic sel, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                           output logic er, output int lat);
    if (sel == P_SEL) begin p_req = 1; p_we = we; p_addr = addr; p_wdata = wd; end
    else begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    rd = '0; er = 1'b0; lat = 0;
    while (lat < 1000) begin
      @(negedge clk);
      lat++;
      if ((sel == P_SEL) ? p_ack : d_ack) begin
        rd = (sel == P_SEL) ? p_rdata : d_rdata;
        er = addr_err;
        if (sel == P_SEL) p_req = 0; else d_req = 0;
        return;
      end
    end
    p_req = 0; d_req = 0; lat = -1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd; logic er; int lat; int k; int busy_drop; int base;
    #1 rst_n = 0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
    checks++; if (state !== ST_CLEAR_SETUP) begin errors++; $display("FAIL reset_state got %0d want %0d", state, ST_CLEAR_SETUP); end
    checks++; if ({p_ack, d_ack, addr_err, clear_done, mem_wr_en} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 00000", {p_ack, d_ack, addr_err, clear_done, mem_wr_en}); end
    checks++; if ({mem_addr, mem_wdata, p_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, p_rdata, d_rdata}); end
    repeat (3) @(negedge clk);
    base = wr_pulses; busy_drop = 0; k = 0;
    rst_n = 1;
    while (k < CLEAR_CYC + 50) begin
      @(negedge clk); k++;
      if (clear_done) break;
      if (!busy) busy_drop++;
    end
    checks++; if (k != CLEAR_CYC) begin errors++; $display("FAIL reset_clear_len got %0d want %0d", k, CLEAR_CYC); end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL reset_busy_gap got %0d want 0", busy_drop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_end got %0b want 0", busy); end
    checks++; if (wr_pulses - base != STORAGE_B) begin errors++; $display("FAIL reset_clear_writes got %0d want %0d", wr_pulses - base, STORAGE_B); end
    @(negedge clk);
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL clear_done_width got %0b want 0", clear_done); end
    model_clear();
    do_access(P_SEL, 0, AW'(95), '0, rd, er, lat);
    checks++; if (rd !== 8'h00 || er !== 1'b0) begin errors++; $display("FAIL read95 got %h/%b want 00/0", rd, er); end
    checks++; if (lat != RD_LAT) begin errors++; $display("FAIL read95_lat got %0d want %0d", lat, RD_LAT); end
    for (int i = 0; i < 6; i++) begin
      logic [AW-1:0] a; a = rand_addr();
      do_access(P_SEL, 0, a, '0, rd, er, lat);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL cleared_read addr %0d got %h want 00", a, rd); end
    end
    last_p_rd = '0;
  endtask

  task automatic test_write_read();
    logic [AW-1:0] s_addr [1:4]; logic [DW-1:0] s_wd [1:4];
    logic [4:1] s_we, s_ack;
    logic [DW-1:0] rd; logic er; int lat;
    p_req = 1; p_we = 1; p_addr = AW'(10); p_wdata = 8'h5A;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      s_addr[i] = mem_addr; s_wd[i] = mem_wdata; s_we[i] = mem_wr_en; s_ack[i] = p_ack;
    end
    p_req = 0;
    checks++; if (s_we !== 4'b0010) begin errors++; $display("FAIL wr_pulse_shape got %b want 0010", s_we); end
    checks++; if (s_ack !== 4'b1000) begin errors++; $display("FAIL wr_ack_latency got %b want 1000", s_ack); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (s_addr[i] !== AW'(10) || s_wd[i] !== 8'h5A) begin
        errors++; $display("FAIL wr_bus_stable cyc %0d got %0d/%h want 10/5a", i, s_addr[i], s_wd[i]); end
    end
    ref_mem[10] = 8'h5A;
    do_access(P_SEL, 0, AW'(10), '0, rd, er, lat);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL rd10 got %h want 5a", rd); end
    checks++; if (lat != RD_LAT) begin errors++; $display("FAIL rd10_lat got %0d want %0d", lat, RD_LAT); end
    last_p_rd = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      logic sel, we; logic [AW-1:0] a; logic [DW-1:0] wd;
      sel = 1'($urandom_range(0, 1)); we = ($urandom_range(0, 2) == 0);
      a = rand_addr(); wd = DW'($urandom);
      do_access(sel, we, a, wd, rd, er, lat);
      checks++; if (lat != (we ? WR_LAT : RD_LAT) || er !== 1'b0) begin
        errors++; $display("FAIL rand_access_timing lat %0d err %b want %0d/0", lat, er, we ? WR_LAT : RD_LAT); end
      if (we) ref_mem[a] = wd;
      else begin
        checks++; if (rd !== ref_mem[a]) begin errors++; $display("FAIL rand_read addr %0d got %h want %h", a, rd, ref_mem[a]); end
        if (sel == P_SEL) last_p_rd = ref_mem[a]; else last_d_rd = ref_mem[a];
      end
      checks++; if (p_rdata !== last_p_rd || d_rdata !== last_d_rd) begin
        errors++; $display("FAIL rdata_hold got %h/%h want %h/%h", p_rdata, d_rdata, last_p_rd, last_d_rd); end
    end
  endtask

  task automatic test_starve();
    int grants; int cyc; int p_in_row; logic got; logic exp;
    p_in_row = 0; grants = 0; cyc = 0;
    p_req = 1; p_we = ($urandom_range(0, 2) == 0); p_addr = rand_addr(); p_wdata = DW'($urandom);
    d_req = 1; d_we = ($urandom_range(0, 2) == 0); d_addr = rand_addr(); d_wdata = DW'($urandom);
    while (grants < 15 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (p_ack && d_ack) begin
        checks++; errors++; $display("FAIL dual_ack got 11 want one");
      end
      if (p_ack || d_ack) begin
        got = d_ack ? D_SEL : P_SEL;
        exp = (p_in_row == STARVE_LIMIT) ? D_SEL : P_SEL;
        checks++; if (got !== exp) begin errors++; $display("FAIL grant_order #%0d got %0b want %0b", grants, got, exp); end
        if (got == P_SEL) p_in_row++; else p_in_row = 0;
        if (got == P_SEL) begin
          if (p_we) ref_mem[p_addr] = p_wdata;
          else begin
            checks++; if (p_rdata !== ref_mem[p_addr]) begin errors++; $display("FAIL starve_p_read got %h want %h", p_rdata, ref_mem[p_addr]); end
            last_p_rd = ref_mem[p_addr];
          end
          checks++; if (d_rdata !== last_d_rd) begin errors++; $display("FAIL starve_d_cross got %h want %h", d_rdata, last_d_rd); end
          p_we = ($urandom_range(0, 2) == 0); p_addr = rand_addr(); p_wdata = DW'($urandom);
        end else begin
          if (d_we) ref_mem[d_addr] = d_wdata;
          else begin
            checks++; if (d_rdata !== ref_mem[d_addr]) begin errors++; $display("FAIL starve_d_read got %h want %h", d_rdata, ref_mem[d_addr]); end
            last_d_rd = ref_mem[d_addr];
          end
          checks++; if (p_rdata !== last_p_rd) begin errors++; $display("FAIL starve_p_cross got %h want %h", p_rdata, last_p_rd); end
          d_we = ($urandom_range(0, 2) == 0); d_addr = rand_addr(); d_wdata = DW'($urandom);
        end
        grants++;
      end
    end
    p_req = 0; d_req = 0;
    checks++; if (grants != 15) begin errors++; $display("FAIL starve_timeout got %0d want 15", grants); end
    @(negedge clk);
  endtask

  task automatic test_addr_err();
    logic [DW-1:0] rd; logic er; int lat; int base; logic [AW-1:0] ma; logic [AW-1:0] a;
    base = wr_pulses; ma = mem_addr;
    do_access(D_SEL, 1, AW'(100), DW'($urandom_range(1, 255)), rd, er, lat);
    checks++; if (er !== 1'b1 || lat != WR_LAT) begin errors++; $display("FAIL oor_write err %b lat %0d want 1/%0d", er, lat, WR_LAT); end
    checks++; if (wr_pulses != base || bad_wr != 0) begin errors++; $display("FAIL oor_write_pulse got %0d/%0d want 0/0", wr_pulses - base, bad_wr); end
    checks++; if (mem_addr !== ma) begin errors++; $display("FAIL oor_addr_moved got %0d want %0d", mem_addr, ma); end
    do_access(D_SEL, 0, AW'(127), '0, rd, er, lat);
    checks++; if (rd !== 8'h00 || er !== 1'b1 || lat != RD_LAT) begin
      errors++; $display("FAIL oor_read127 got %h/%b/%0d want 00/1/%0d", rd, er, lat, RD_LAT); end
    last_d_rd = '0;
    a = AW'($urandom_range(STORAGE_B, 127));
    do_access(P_SEL, 0, a, '0, rd, er, lat);
    checks++; if (rd !== 8'h00 || er !== 1'b1) begin errors++; $display("FAIL oor_read addr %0d got %h/%b want 00/1", a, rd, er); end
    last_p_rd = '0;
    a = rand_addr();
    do_access(D_SEL, 0, a, '0, rd, er, lat);
    checks++; if (rd !== ref_mem[a] || er !== 1'b0) begin errors++; $display("FAIL inrange_after_err got %h/%b want %h/0", rd, er, ref_mem[a]); end
    last_d_rd = ref_mem[a];
  endtask

  task automatic test_clear_during_write();
    logic [AW-1:0] a; logic [DW-1:0] wd; int k; int k_done; int k_ack; int lat; logic [DW-1:0] rd;
    a = rand_addr(); wd = DW'($urandom_range(1, 255));
    p_req = 1; p_we = 1; p_addr = a; p_wdata = wd;
    @(negedge clk); clear_req = 1; lat = 1;
    while (!p_ack && lat < 50) begin @(negedge clk); lat++; end
    p_req = 0;
    checks++; if (lat != WR_LAT) begin errors++; $display("FAIL clear_wr_ack_lat got %0d want %0d", lat, WR_LAT); end
    @(negedge clk); k = 1;
    clear_req = 0;
    checks++; if (state !== ST_CLEAR_SETUP || busy !== 1'b1) begin errors++; $display("FAIL clear_start got %0d/%b want %0d/1", state, busy, ST_CLEAR_SETUP); end
    p_req = 1; p_we = 0; p_addr = a;
    k_done = -1; k_ack = -1; rd = '1;
    while (k < CLEAR_CYC + 60 && k_ack < 0) begin
      @(negedge clk); k++;
      if (clear_done) k_done = k;
      if (p_ack) begin k_ack = k; rd = p_rdata; p_req = 0; end
    end
    p_req = 0;
    checks++; if (k_done != CLEAR_CYC + 1) begin errors++; $display("FAIL clear_done_time got %0d want %0d", k_done, CLEAR_CYC + 1); end
    checks++; if (k_ack != CLEAR_CYC + 1 + RD_LAT) begin errors++; $display("FAIL post_clear_ack got %0d want %0d", k_ack, CLEAR_CYC + 1 + RD_LAT); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL post_clear_read got %h want 00", rd); end
    model_clear(); last_p_rd = '0;
  endtask

  task automatic test_reset_mid_write();
    logic [AW-1:0] a; int k; int k_done; int k_ack; logic [DW-1:0] rd;
    a = rand_addr();
    p_req = 1; p_we = 1; p_addr = a; p_wdata = DW'($urandom_range(1, 255));
    repeat (2) @(negedge clk);
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL mid_wr_pulse got %b want 1", mem_wr_en); end
    rst_n = 0;
    #1;
    checks++; if (mem_wr_en !== 1'b0 || p_ack !== 1'b0) begin errors++; $display("FAIL async_abort got %b/%b want 0/0", mem_wr_en, p_ack); end
    checks++; if (state !== ST_CLEAR_SETUP || busy !== 1'b1) begin errors++; $display("FAIL abort_state got %0d/%b want %0d/1", state, busy, ST_CLEAR_SETUP); end
    p_we = 0;
    @(negedge clk); rst_n = 1; k = 0;
    k_done = -1; k_ack = -1; rd = '1;
    while (k < CLEAR_CYC + 60 && k_ack < 0) begin
      @(negedge clk); k++;
      if (clear_done) k_done = k;
      if (p_ack) begin k_ack = k; rd = p_rdata; p_req = 0; end
    end
    p_req = 0;
    checks++; if (k_done != CLEAR_CYC) begin errors++; $display("FAIL rst_clear_time got %0d want %0d", k_done, CLEAR_CYC); end
    checks++; if (k_ack != CLEAR_CYC + RD_LAT) begin errors++; $display("FAIL rst_first_grant got %0d want %0d", k_ack, CLEAR_CYC + RD_LAT); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_read got %h want 00", rd); end
    model_clear(); last_p_rd = '0; last_d_rd = '0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_starve();
    test_addr_err();
    test_clear_during_write();
    test_reset_mid_write();
    test_write_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
